// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle FSM and the MIPS datapath.
// master: FSM side (Op/Zero/MemReady in, controls out); slave: datapath side.
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Op;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       AluOp;
  logic [1:0]       PCSource;
  logic [3:0]       State;
  logic             IllegalOp;
  logic             Retire;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Op, Zero, MemReady,
    output PCWrite, PCWriteCond, IorD,
    output MemRead, MemWrite, IRWrite,
    output MemtoReg, RegDst, RegWrite,
    output ALUSrcA, ALUSrcB, AluOp,
    output PCSource, State, IllegalOp,
    output Retire, InstrCount
  );

  modport slave (
    output Op, Zero, MemReady,
    input  PCWrite, PCWriteCond, IorD,
    input  MemRead, MemWrite, IRWrite,
    input  MemtoReg, RegDst, RegWrite,
    input  ALUSrcA, ALUSrcB, AluOp,
    input  PCSource, State, IllegalOp,
    input  Retire, InstrCount
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with memory-ready stalls and retire counter.
// Ports: clk, reset_n (sync, active-low), bus (master modport of the ctrl interface).
module mips_multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset_n,
  mips_multicycle_ctrl_if.master bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dec_st;
  logic             is_lw, is_sw, is_rt;
  logic             is_beq, is_addi, is_j;
  logic             unused_zero;

  // Zero is qualified in the datapath through PCWriteCond.
  assign unused_zero = bus.Zero;

  assign is_lw   = (bus.Op == OP_LW);
  assign is_sw   = (bus.Op == OP_SW);
  assign is_rt   = (bus.Op == OP_RTYP);
  assign is_beq  = (bus.Op == OP_BEQ);
  assign is_addi = (bus.Op == OP_ADDI);
  assign is_j    = (bus.Op == OP_J);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:
        state_d = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEMADR;
          is_rt:        state_d = S_RTYPEEX;
          is_beq:       state_d = S_BEQEX;
          is_addi:      state_d = S_ADDIEX;
          is_j:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        unique case (1'b1)
          is_lw:   state_d = S_MEMRD;
          is_sw:   state_d = S_MEMWR;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMRD:
        state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:
        state_d = bus.MemReady ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // In reset the controls decode as FETCH, with no writes.
  assign dec_st = reset_n ? state_q : S_FETCH;

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.AluOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.IllegalOp   = 1'b0;
    bus.Retire      = 1'b0;
    unique case (dec_st)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MemReady & reset_n;
        bus.PCWrite = bus.MemReady & reset_n;
      end
      S_DECODE: begin
        bus.ALUSrcB   = 2'b11;
        bus.IllegalOp = ~(is_lw | is_sw | is_rt |
                          is_beq | is_addi | is_j);
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
        bus.Retire   = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        bus.Retire   = bus.MemReady;
      end
      S_RTYPEEX: begin
        bus.ALUSrcA = 1'b1;
        bus.AluOp   = 2'b10;
      end
      S_RTYPEWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
        bus.Retire   = 1'b1;
      end
      S_BEQEX: begin
        bus.ALUSrcA     = 1'b1;
        bus.AluOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        bus.Retire      = 1'b1;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        bus.RegWrite = 1'b1;
        bus.Retire   = 1'b1;
      end
      S_JEX: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        bus.Retire   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.Retire) cnt_d = cnt_q + CNT_W'(1);
  end

  assign bus.State      = state_q;
  assign bus.InstrCount = cnt_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle main control FSM for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback. In each state it drives the register-file, memory, PC and mux selects, plus the 2-bit `AluOp` consumed by the ALU control decoder. Memory accesses are stretched by a ready handshake, and an instruction-retire counter is kept for performance debug.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `Op`  in  6  opcode, IR[31:26]; valid from DECODE onward.
- `Zero`  in  1  ALU zero flag. It is not used internally and is gated in the datapath via `PCWriteCond`.
- `MemReady`  in  1  memory completes the current read or write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each  datapath controls.
- `ALUSrcB`  out  2  ALU B mux select: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2.
- `AluOp`  out  2  to ALU control: 00 add, 01 subtract, 10 decode funct field.
- `PCSource`  out  2  PC mux select: 00 ALU result, 01 ALUOut register, 10 jump target.
- `State`  out  4  current state encoding.
- `IllegalOp`  out  1  one-cycle pulse when an undefined opcode is decoded.
- `Retire`  out  1  one-cycle pulse in the last state of each instruction.
- `InstrCount`  out  CNT_W  count of retired instructions.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 are unreachable and return to FETCH on the next edge.
- Every output not listed for a state is 0, including 2-bit fields, which are 00.
- FETCH:
  - Drives `MemRead`=1, `ALUSrcB`=01.
  - `IRWrite`=1 and `PCWrite`=1 only in the cycle where `MemReady`=1; the state advances to DECODE on that cycle, otherwise it holds.
- DECODE:
  - Drives `ALUSrcB`=11 to precompute the branch target.
  - Next state by `Op`: 100011 (lw) or 101011 (sw) → MEMADR; 000000 → RTYPEEX; 000100 → BEQEX; 001000 → ADDIEX; 000010 → JEX.
  - Any other `Op` → FETCH, with `IllegalOp`=1 in this cycle.
- MEMADR:
  - Drives `ALUSrcA`=1, `ALUSrcB`=10.
  - Next state: lw → MEMRD, sw → MEMWR. `Op` is re-sampled here and is held stable by the IR.
- MEMRD: drives `MemRead`=1, `IorD`=1; holds until `MemReady`=1, then → MEMWB.
- MEMWB: drives `MemtoReg`=1, `RegWrite`=1, `Retire`=1; → FETCH.
- MEMWR: drives `MemWrite`=1, `IorD`=1; holds until `MemReady`=1. In that cycle `Retire`=1 and the next state is FETCH.
- RTYPEEX: drives `ALUSrcA`=1, `ALUSrcB`=00, `AluOp`=10; → RTYPEWB.
- RTYPEWB: drives `RegDst`=1, `RegWrite`=1, `Retire`=1; → FETCH.
- BEQEX: drives `ALUSrcA`=1, `AluOp`=01, `PCWriteCond`=1, `PCSource`=01, `Retire`=1; → FETCH.
- ADDIEX: drives `ALUSrcA`=1, `ALUSrcB`=10; → ADDIWB.
- ADDIWB: drives `RegWrite`=1, `Retire`=1; → FETCH.
- JEX: drives `PCWrite`=1, `PCSource`=10, `Retire`=1; → FETCH.
- `InstrCount` increments by 1 on each edge where `Retire`=1 and wraps from all-ones to 0. Illegal opcodes do not count.

## Timing
- On any edge with `reset_n`=0, the state becomes FETCH and `InstrCount` becomes 0. This holds mid-instruction, including while waiting on `MemReady`; no partial writeback completes.
- While in reset, outputs decode from FETCH: `MemRead`=1, `ALUSrcB`=01, everything else 0. `IRWrite` and `PCWrite` are forced to 0 while `reset_n`=0.
- Outputs are combinational from the state. The only `MemReady`-dependent outputs are `IRWrite`, `PCWrite` in FETCH and `Retire` in MEMWR.
- Cycles per instruction with `MemReady` tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each stall cycle of `MemReady`=0 adds 1.
- Memory request signals (`MemRead`/`MemWrite`, `IorD`) stay constant for the entire wait.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles from an arbitrary state. Expect `State`=0, `InstrCount`=0, `RegWrite`=`MemWrite`=`PCWrite`=`IRWrite`=0.
- lw, `Op`=100011, `MemReady`=1: expect `State` sequence 0,1,2,3,4,0; `RegWrite`=1 with `MemtoReg`=1 only in state 4; `InstrCount` goes 0→1.
- R-type, `Op`=000000: expect `AluOp`=10 only in state 6, `RegDst`=`RegWrite`=1 in state 7. beq, `Op`=000100: expect `AluOp`=01, `PCWriteCond`=1 in state 8, 3 cycles total.
- sw with `MemReady` low for 3 cycles in MEMWR: expect `State`=5 for 4 cycles with `MemWrite`=`IorD`=1 throughout, a single `Retire` pulse on the ready cycle, then `State`=0.
- Illegal opcode 111111: expect `IllegalOp`=1 for one cycle in DECODE, then `State`=0, with `InstrCount` unchanged.
- Assert `reset_n`=0 for one cycle while in MEMRD with `MemReady`=0: expect FETCH next, no `RegWrite` pulse, and `InstrCount`=0.
